// File: rtl/fetch_pkt_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkt_packer_pkg
// Purpose  : Shared frontend definitions. Fetch, packer and the compressing
//            instruction FIFO all import this package so that they agree on
//            the packet geometry and the slot payload type.
// Contents : FETCH_WIDTH / WRITE_PORT / DATA_WIDTH constants, derived counter
//            widths, slot payload type, fetch packet struct, packer states.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkt_packer_pkg;

  localparam int FETCH_WIDTH = 4;   // slots per fetch packet (power of two)
  localparam int WRITE_PORT  = 2;   // FIFO write lanes (fixed)
  localparam int DATA_WIDTH  = 32;  // payload bits per slot

  localparam int REM_W  = $clog2(FETCH_WIDTH) + 1;  // holds 0..FETCH_WIDTH
  localparam int HEAD_W = $clog2(FETCH_WIDTH);      // buffer index
  localparam int NUM_W  = $clog2(WRITE_PORT + 1);   // holds 0..WRITE_PORT

  typedef logic [DATA_WIDTH-1:0] dtype;

  // One fetch packet as produced by the fetch stage output register.
  typedef struct packed {
    logic [FETCH_WIDTH-1:0] mask;
    dtype [FETCH_WIDTH-1:0] data;
  } fetch_pkt_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,   // nothing buffered, ready for a packet
    ST_DRAIN = 1'b1    // compacted slots waiting to be written
  } pack_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pkt_packer_slot_compactor.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkt_packer_slot_compactor
// Purpose  : Combinational compaction of a masked slot vector. Valid slots are
//            packed, in ascending slot order, into output positions 0..count-1;
//            remaining positions are driven to zero.
// Ports    : mask        - per-slot valid, bit i = slot i
//            data        - slot payloads
//            packed_data - compacted payloads, position 0 = oldest valid slot
//            count       - popcount(mask)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pkt_packer_slot_compactor
  import fetch_pkt_packer_pkg::*;
#(
  parameter int SLOTS = FETCH_WIDTH,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [SLOTS-1:0]            mask,
  input  logic [SLOTS-1:0][WIDTH-1:0] data,
  output logic [SLOTS-1:0][WIDTH-1:0] packed_data,
  output logic [$clog2(SLOTS):0]      count
);

  localparam int CW = $clog2(SLOTS) + 1;

  // prefix[i] = number of valid slots below slot i = destination of slot i.
  logic [SLOTS:0][CW-1:0] prefix;

  always_comb begin
    prefix[0] = '0;
    for (int i = 0; i < SLOTS; i++) begin
      prefix[i+1] = prefix[i] + CW'(mask[i]);
    end
  end

  // Each output position ORs in the one valid slot whose prefix selects it;
  // at most one slot matches, so the OR acts as a one-hot mux.
  always_comb begin
    packed_data = '0;
    for (int j = 0; j < SLOTS; j++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (mask[i] && (prefix[i] == CW'(j))) begin
          packed_data[j] = packed_data[j] | data[i];
        end
      end
    end
  end

  assign count = prefix[SLOTS];

endmodule
`default_nettype wire

// File: rtl/fetch_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkt_packer
// Purpose  : Producer-side front end of the compressing instruction FIFO.
//            Accepts one masked fetch packet per handshake, compacts the valid
//            slots and drains them into the 2-wide FIFO write port.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            flush_i           - discard any held packet
//            pkt_valid_i/pkt_ready_o/pkt_mask_i/pkt_data_i - packet input
//            write_valid_o/write_ready_i/write_num_o/write_data_o - FIFO write
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pkt_packer
  import fetch_pkt_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [FETCH_WIDTH-1:0] pkt_mask_i,
  input  dtype [FETCH_WIDTH-1:0] pkt_data_i,
  output logic                   write_valid_o,
  input  logic                   write_ready_i,
  output logic [NUM_W-1:0]       write_num_o,
  output dtype [WRITE_PORT-1:0]  write_data_o
);

  pack_state_e             state_q, state_d;
  dtype [FETCH_WIDTH-1:0]  buf_q, buf_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [HEAD_W-1:0]       head_q, head_d;

  dtype [FETCH_WIDTH-1:0]  cmp_data;
  logic [REM_W-1:0]        cmp_count;

  logic fire;
  logic last_chunk;
  logic accept;

  fetch_pkt_packer_slot_compactor #(
    .SLOTS (FETCH_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_compactor (
    .mask        (pkt_mask_i),
    .data        (pkt_data_i),
    .packed_data (cmp_data),
    .count       (cmp_count)
  );

  // Write-side outputs depend only on registered state.
  assign write_valid_o = (state_q == ST_DRAIN);
  assign write_num_o   = (rem_q > REM_W'(WRITE_PORT)) ? NUM_W'(WRITE_PORT)
                                                      : rem_q[NUM_W-1:0];

  generate
    for (genvar i = 0; i < WRITE_PORT; i++) begin : g_lane
      logic [HEAD_W-1:0] lane_idx;
      assign lane_idx        = head_q + HEAD_W'(i);
      assign write_data_o[i] = (NUM_W'(i) < write_num_o) ? buf_q[lane_idx] : '0;
    end
  endgenerate

  assign fire       = write_valid_o & write_ready_i;
  assign last_chunk = (rem_q <= REM_W'(WRITE_PORT));
  // A new packet may land in the same cycle the final chunk drains.
  assign pkt_ready_o = rst_n & ~flush_i & ((state_q == ST_IDLE) | (fire & last_chunk));
  assign accept      = pkt_valid_i & pkt_ready_o;

  always_comb begin
    rem_d  = rem_q;
    head_d = head_q;
    buf_d  = buf_q;
    if (fire) begin
      rem_d  = rem_q - REM_W'(write_num_o);
      head_d = head_q + HEAD_W'(write_num_o);
    end
    // Flush wins over accept; a fire in the flush cycle is still consumed by
    // the FIFO, which flushes itself independently.
    if (flush_i) begin
      rem_d  = '0;
      head_d = '0;
    end else if (accept) begin
      rem_d  = cmp_count;
      head_d = '0;
      buf_d  = cmp_data;
    end
    state_d = (rem_d != '0) ? ST_DRAIN : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      head_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      head_q  <= head_d;
      buf_q   <= buf_d;
    end
  end

endmodule
`default_nettype wire
